// File: rtl/ddr3_app_responder.sv
// Behavioural DDR3 MIG app-interface responder: calibration delay, 128-bit word memory, fixed-latency reads.
// Optional macro DDR3_RESP_STALL_EN adds LFSR-driven ready stalls after calibration.
module ddr3_app_responder #(
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned CALIB_CYCLES = 64,
  parameter int unsigned RD_LATENCY   = 8
) (
  input  logic         ui_clk,
  input  logic         rst_n,
  output logic         init_calib_complete,
  output logic         app_rdy,
  output logic         app_wdf_rdy,
  input  logic [27:0]  app_addr,
  input  logic         app_en,
  input  logic [2:0]   app_cmd,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  input  logic [127:0] app_wdf_data,
  output logic         app_rd_data_valid,
  output logic [127:0] app_rd_data,
  output logic         cmd_err
);

  localparam int unsigned DW    = 128;
  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam int unsigned CNT_W = $clog2(CALIB_CYCLES + 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  calib_q, calib_d;
  logic                  rdy_q, rdy_d;
  logic                  wdf_rdy_q, wdf_rdy_d;
  logic                  err_q, err_d;
  logic [RD_LATENCY-1:0] vld_q;
  logic [DW-1:0]         dat_q [RD_LATENCY];
  logic [DW-1:0]         rd_word_d;
  logic [DW-1:0]         mem [DEPTH];
  logic [MEM_AW-1:0]     idx_c;
  logic                  err_now_c;
  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic                  unused_addr_c;

`ifdef DDR3_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
`endif

  // Byte address to word index; upper bits alias so accesses wrap.
  assign idx_c         = app_addr[MEM_AW+2:3];
  assign unused_addr_c = ^{app_addr[27:MEM_AW+3], app_addr[2:0]};

  // Next-state logic: calibration, ready gating, protocol checks, read launch.
  always_comb begin
    cnt_d     = cnt_q;
    calib_d   = calib_q;
    err_now_c = 1'b0;
    wr_acc_c  = 1'b0;
    rd_acc_c  = 1'b0;
    rd_word_d = '0;

    if (!calib_q) begin
      if (cnt_q == CNT_W'(CALIB_CYCLES - 1)) calib_d = 1'b1;
      else                                   cnt_d   = cnt_q + CNT_W'(1);
    end

`ifdef DDR3_RESP_STALL_EN
    lfsr_d = lfsr_q;
    if (calib_q) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    rdy_d     = calib_d && (lfsr_d[1:0] != 2'b00);
    wdf_rdy_d = calib_d && (lfsr_d[3:2] != 2'b00);
`else
    rdy_d     = calib_d;
    wdf_rdy_d = calib_d;
`endif

    // Commands while not ready are ignored silently, so every check is qualified by ready.
    if (rdy_q) begin
      err_now_c = (app_en && (app_cmd != 3'd0) && (app_cmd != 3'd1))
               || (app_en && (app_cmd == 3'd0) && !app_wdf_wren)
               || (app_wdf_wren && !(app_en && (app_cmd == 3'd0)))
               || (app_wdf_end != app_wdf_wren);
    end

    wr_acc_c = app_en && (app_cmd == 3'd0) && app_wdf_wren && app_wdf_end
            && rdy_q && wdf_rdy_q && !err_now_c;
    rd_acc_c = app_en && (app_cmd == 3'd1) && rdy_q && !err_now_c;

    // Snapshot at accept so later writes cannot disturb an in-flight read.
    if (rd_acc_c) rd_word_d = mem[idx_c];

    err_d = err_q || err_now_c;
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      calib_q   <= 1'b0;
      rdy_q     <= 1'b0;
      wdf_rdy_q <= 1'b0;
      err_q     <= 1'b0;
      vld_q     <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) dat_q[i] <= '0;
`ifdef DDR3_RESP_STALL_EN
      lfsr_q    <= 16'hACE1;
`endif
    end else begin
      cnt_q     <= cnt_d;
      calib_q   <= calib_d;
      rdy_q     <= rdy_d;
      wdf_rdy_q <= wdf_rdy_d;
      err_q     <= err_d;
      vld_q     <= {vld_q[RD_LATENCY-2:0], rd_acc_c};
      dat_q[0]  <= rd_word_d;
      for (int i = 1; i < int'(RD_LATENCY); i++) dat_q[i] <= dat_q[i-1];
`ifdef DDR3_RESP_STALL_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  // Storage survives reset.
  always_ff @(posedge ui_clk) begin
    if (wr_acc_c) mem[idx_c] <= app_wdf_data;
  end

  assign init_calib_complete = calib_q;
  assign app_rdy             = rdy_q;
  assign app_wdf_rdy         = wdf_rdy_q;
  assign cmd_err             = err_q;
  assign app_rd_data_valid   = vld_q[RD_LATENCY-1];
  assign app_rd_data         = dat_q[RD_LATENCY-1];

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Scoreboard bench for ddr3_app_responder: expected reads queued at issue, checked when valid appears.
module tb_ddr3_app_responder;

  localparam int unsigned MEM_AW = 10;
  localparam int unsigned CALIB  = 64;
  localparam int unsigned LAT    = 8;

  logic         ui_clk = 1'b0;
  logic         rst_n;
  logic         init_calib_complete;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic [27:0]  app_addr;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [127:0] app_wdf_data;
  logic         app_rd_data_valid;
  logic [127:0] app_rd_data;
  logic         cmd_err;

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         sb [$];
  logic [127:0] model [int];
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;

  always #5 ui_clk = ~ui_clk;
  always @(posedge ui_clk) cyc <= cyc + 1;

  ddr3_app_responder #(
    .MEM_AW       (MEM_AW),
    .CALIB_CYCLES (CALIB),
    .RD_LATENCY   (LAT)
  ) dut (
    .ui_clk              (ui_clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_addr            (app_addr),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_data        (app_wdf_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data         (app_rd_data),
    .cmd_err             (cmd_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int word_idx(input logic [27:0] a);
    return int'(a[MEM_AW+2:3]);
  endfunction

  task automatic step();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic idle();
    app_en       = 1'b0;
    app_cmd      = 3'd0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    app_wdf_data = '0;
  endtask

  task automatic wr(input logic [27:0] a, input logic [127:0] d);
    app_en       = 1'b1;
    app_cmd      = 3'd0;
    app_addr     = a;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    app_wdf_data = d;
    model[word_idx(a)] = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [27:0] a);
    exp_t e;
    app_en   = 1'b1;
    app_cmd  = 3'd1;
    app_addr = a;
    e.data   = model[word_idx(a)];
    e.due    = cyc + int'(LAT);
    sb.push_back(e);
    step();
    idle();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("drain", 128'(sb.size()), 128'(0));
  endtask

  task automatic reset_and_calib();
    int n;
    rst_n = 1'b0;
    #1;
    check("rst_calib",   128'(init_calib_complete), 128'(0));
    check("rst_rdy",     128'(app_rdy),             128'(0));
    check("rst_wdf_rdy", 128'(app_wdf_rdy),         128'(0));
    check("rst_valid",   128'(app_rd_data_valid),   128'(0));
    check("rst_data",    app_rd_data,               128'(0));
    check("rst_err",     128'(cmd_err),             128'(0));
    repeat (3) step();
    rst_n = 1'b1;
    n = 0;
    while (n < 200) begin
      step();
      n++;
      if (init_calib_complete) break;
      check("rdy_low_in_calib", 128'(app_rdy), 128'(0));
    end
    check("calib_cycles",     128'(n),           128'(CALIB));
    check("rdy_at_calib",     128'(app_rdy),     128'(1));
    check("wdf_rdy_at_calib", 128'(app_wdf_rdy), 128'(1));
  endtask

  // Read-side monitor away from the active edge.
  always @(negedge ui_clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1) begin
      if (app_rd_data_valid) begin
        if (sb.size() == 0) begin
          check("rd_unexpected", 128'(app_rd_data_valid), 128'(0));
        end else begin
          e = sb.pop_front();
          check("rd_data",  app_rd_data, e.data);
          check("rd_cycle", 128'(cyc),   128'(e.due));
        end
      end else begin
        check("rd_idle_zero", app_rd_data, 128'(0));
        if (sb.size() != 0 && cyc > sb[0].due) begin
          e = sb.pop_front();
          check("rd_missing", 128'(app_rd_data_valid), 128'(1));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    idle();
    app_addr = '0;
    reset_and_calib();

    // Write then read-after-write in the following cycle.
    wr(28'h0000010, 128'h1234);
    rd(28'h0000010);
    drain();

    // Sixteen back-to-back reads of distinct words.
    for (int i = 0; i < 16; i++) wr(28'h0000100 + 28'(i * 8), 128'(i));
    for (int i = 0; i < 16; i++) rd(28'h0000100 + 28'(i * 8));
    drain();

    // Index aliasing above the memory depth.
    wr(28'h0002000, 128'hCAFE_F00D_0BAD_BEEF);
    rd(28'h0000000);
    drain();

    // Illegal command sets the sticky error.
    check("err_clean", 128'(cmd_err), 128'(0));
    app_en   = 1'b1;
    app_cmd  = 3'd2;
    app_addr = 28'h0000010;
    step();
    idle();
    check("err_set", 128'(cmd_err), 128'(1));

    // Write with end/wren mismatch must not store.
    app_en       = 1'b1;
    app_cmd      = 3'd0;
    app_addr     = 28'h0000010;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b0;
    app_wdf_data = 128'hDEAD;
    step();
    idle();
    rd(28'h0000010);
    drain();
    repeat (5) step();
    check("err_sticky", 128'(cmd_err), 128'(1));

    // Reset with reads in flight.
    for (int i = 0; i < 4; i++) rd(28'h0000100 + 28'(i * 8));
    repeat (3) step();
    sb.delete();
    reset_and_calib();
    repeat (20) step();

    // Memory survives reset.
    rd(28'h0002000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr3_app_responder.md
DDR3_APP_RESPONDER -- requirements
Module: ddr3_app_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning the number of 128-bit memory word index bits (depth 2^MEM_AW).
REQ-002 SHALL have parameter CALIB_CYCLES, default 64, meaning the cycles from reset release to calibration complete.
REQ-003 SHALL have parameter RD_LATENCY, default 8, legal range 2..32, meaning the cycles from read accept to data valid.
REQ-004 ui_clk  input  1  sole clock, all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 init_calib_complete  output  1  calibration done.
REQ-007 app_rdy  output  1  command accept ready.
REQ-008 app_wdf_rdy  output  1  write-data accept ready.
REQ-009 app_addr  input  28  command address, byte-granular, burst step 8.
REQ-010 app_en  input  1  command valid.
REQ-011 app_cmd  input  3  0 = write, 1 = read, other values illegal.
REQ-012 app_wdf_wren  input  1  write data valid.
REQ-013 app_wdf_end  input  1  last beat of write data (BL8 with 4:1 ratio, so always equal to wren).
REQ-014 app_wdf_data  input  128  write data.
REQ-015 app_rd_data_valid  output  1  read data valid.
REQ-016 app_rd_data  output  128  read data.
REQ-017 cmd_err  output  1  sticky protocol-error flag.

Function
REQ-018 SHALL count CALIB_CYCLES cycles after reset, then assert init_calib_complete and hold it high until the next reset.
REQ-019 SHALL drive app_rdy and app_wdf_rdy low while init_calib_complete is low.
REQ-020 SHALL index memory with app_addr[MEM_AW+2:3]; higher address bits SHALL be ignored, so accesses wrap modulo the depth.
REQ-021 SHALL accept a write in a cycle where app_en, app_cmd==0, app_wdf_wren, app_wdf_end, app_rdy and app_wdf_rdy are all high; the word is stored at the end of that cycle.
REQ-022 SHALL accept a read in a cycle where app_en, app_cmd==1 and app_rdy are all high.
REQ-023 SHALL assert app_rd_data_valid for exactly one cycle, RD_LATENCY cycles after each read accept, together with that word.
REQ-024 SHALL return read data in accept order and SHALL sustain one read accept per cycle with no loss.
REQ-025 A read accepted in the cycle after a write to the same index SHALL return the newly written data.
REQ-026 SHALL drive app_rd_data to 0 whenever app_rd_data_valid is low.
REQ-027 Any of the following SHALL set cmd_err, which stays high until reset; the offending command SHALL be ignored:
  - app_en with app_cmd not in {0,1} while app_rdy is high;
  - an app_cmd==0 accept attempt with app_wdf_wren low;
  - app_wdf_wren high without app_en and app_cmd==0;
  - app_wdf_end differing from app_wdf_wren.
REQ-028 Commands presented while app_rdy is low SHALL be ignored without setting cmd_err.

Reset
REQ-029 On rst_n low, the following SHALL be 0 immediately: init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data, cmd_err, the calibration counter and the whole read pipeline.
REQ-030 Reset mid-operation SHALL discard in-flight reads (no valid pulse after reset) and restart calibration; memory contents are not cleared.

Configuration
REQ-031 Macro DDR3_RESP_STALL_EN.
  - When defined: after calibration, app_rdy and app_wdf_rdy SHALL be independently gated by a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11, advanced every cycle after calibration).
  - Gating rule: app_rdy is low when LFSR[1:0]==2'b00; app_wdf_rdy is low when LFSR[3:2]==2'b00.
  - When not defined: app_rdy and app_wdf_rdy SHALL equal init_calib_complete, and no LFSR logic is present.

Verification
REQ-032 Release reset, no commands -> init_calib_complete rises exactly 64 cycles later; app_rdy rises in the same cycle (macro off).
REQ-033 Write 128'h1234 to addr 28'h0000010, then read addr 28'h0000010 the next cycle -> app_rd_data_valid 8 cycles after the read, data 128'h1234.
REQ-034 Back-to-back reads of 16 consecutive addresses (step 8), each previously written with its index -> 16 consecutive valid cycles, data 0..15 in order.
REQ-035 Write to addr 28'h0002000 (index 1024 with MEM_AW=10), then read addr 28'h0 -> returns the written value (wrap).
REQ-036 Issue app_cmd=3'd2 with app_en high -> cmd_err goes high the next cycle and stays high; memory is unchanged, no valid pulse.
REQ-037 Issue 4 reads, assert rst_n low 3 cycles later -> no app_rd_data_valid pulse afterwards; calibration restarts and completes 64 cycles after reset release.
